// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view, synchronous load and wrap pulse.
// Build option: define GRAY_COUNTER_SATURATE_EN to clamp at the limits instead of wrapping.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_step;
  logic             w_at_limit;
  logic             w_wrap_next;

  // A step sitting on the limit in its own direction is a wrap (modulo build)
  // or a blocked step (saturating build); both raise the same pulse.
  always_comb begin
    w_step      = en & ~load;
    w_at_limit  = up ? (r_cnt == CNT_MAX) : (r_cnt == '0);
    w_wrap_next = w_step & w_at_limit;
  end

  always_comb begin
    w_next = r_cnt;
    if (load) begin
      w_next = load_val;
    end else if (en) begin
`ifdef GRAY_COUNTER_SATURATE_EN
      if (!w_at_limit) begin
        w_next = up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
      end
`else
      w_next = up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
`endif
    end
  end

  // Gray is computed from the next binary value so both registers update together.
  always_comb begin
    w_next_gray = w_next ^ (w_next >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_next;
      r_gray <= w_next_gray;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_cnt;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;

endmodule
